ram_write_arbiter: RTL and testbench
====================================

RAM_WRITE_ARBITER -- requirements
Module: ram_write_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 2: number of write sources (2..8).
REQ-002 Parameter ADDR_W, default 6: RAM address width.
REQ-003 Parameter PIXEL_W, default 8: pixel/data width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 src_valid  input  NUM_SRC  per-source write request.
REQ-007 src_ready  output  NUM_SRC  per-source accept; a beat transfers when valid and ready are both high at a rising edge.
REQ-008 src_addr  input  NUM_SRC*ADDR_W  packed addresses; source i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 src_data  input  NUM_SRC*PIXEL_W  packed data; source i occupies bits [i*PIXEL_W +: PIXEL_W].
REQ-010 ram_busy  input  1  RAM cannot take a write this cycle.
REQ-011 ram_we  output  1  registered one-cycle write strobe.
REQ-012 ram_addr  output  ADDR_W  registered write address.
REQ-013 ram_data  output  PIXEL_W  registered write data.
REQ-014 grant_id  output  $clog2(NUM_SRC)  source index of the current ram_we beat.

Function
REQ-015 Each source SHALL have a one-entry holding buffer (buf_valid, addr, data).
REQ-016 src_ready[i] SHALL equal !buf_valid[i] OR (grant this cycle to i), allowing one beat per source per cycle.
REQ-017 When ram_busy is low and any buf_valid is set, exactly one source SHALL be granted per cycle; with ram_busy high, nothing is granted and buffers hold.
REQ-018 A granted entry SHALL appear on ram_we/ram_addr/ram_data/grant_id in the cycle after the grant: 1-cycle latency from buffer to RAM port.
REQ-019 ram_we SHALL be high for exactly one cycle per granted beat and low otherwise; ram_addr, ram_data and grant_id hold their last values while ram_we is low.
REQ-020 Default arbitration SHALL be round-robin: the search starts at (last_grant+1) mod NUM_SRC; last_grant updates only on a grant.
REQ-021 Simultaneous push and pop on the same source SHALL replace the entry with the new beat and keep buf_valid set.
REQ-022 Beats from a single source SHALL reach the RAM in acceptance order; no beat is dropped or duplicated.

Reset
REQ-023 With rst_n low at a rising edge: buf_valid all 0; ram_we 0; ram_addr, ram_data and grant_id all 0; last_grant = NUM_SRC-1, so source 0 wins first.
REQ-024 Reset mid-operation SHALL discard buffered beats. During reset src_ready SHALL be all 0.

Configuration
REQ-025 Macro WRARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority (lowest index wins) and last_grant is unused; when undefined, round-robin per REQ-020. Ports are identical in both builds.

Structure
REQ-026 Package skel_pkg SHALL hold the default widths (ADDR_W, PIXEL_W) and the NUM_SRC limit constant, shared with the RAM and the skeletonization core.
REQ-027 Arbitration SHALL be a sub-module rr_arbiter (request vector in, one-hot grant out, pointer state inside); buffers and the output register stay in ram_write_arbiter.

Verification
REQ-028 Reset release, no valids -> ram_we stays 0 and src_ready = all 1 from the first post-reset cycle.
REQ-029 Single source: src 0 pushes addr 5, data 0xAA -> ram_we pulses the cycle after the grant with ram_addr=5, ram_data=0xAA, grant_id=0.
REQ-030 NUM_SRC=2, both continuously valid -> grant_id alternates 0,1,0,1 with ram_we high every cycle; fixed-priority build -> grant_id stays 0 and src 1 stalls.
REQ-031 ram_busy high for 3 cycles with both buffers full -> ram_we low, src_ready all 0, no data lost; after release, both beats are written in successive cycles.
REQ-032 rst_n pulled low with both buffers full -> no write issued after reset, and the first later grant goes to source 0.

Source files
------------

// File: rtl/skel_pkg.sv
// Shared constants for the skeletonization datapath: default RAM widths, the
// write-source limit, and a one-hot to index encoder.
//
// Contents:
//   SKEL_ADDR_W     default RAM address width
//   SKEL_PIXEL_W    default pixel/data width
//   SKEL_MAX_SRC    largest supported number of RAM write sources
//   SKEL_MAX_IDX_W  index width covering SKEL_MAX_SRC sources
//   onehot_to_idx   encode a one-hot vector (up to SKEL_MAX_SRC bits) to its index
package skel_pkg;

    localparam int unsigned SKEL_ADDR_W    = 6;
    localparam int unsigned SKEL_PIXEL_W   = 8;
    localparam int unsigned SKEL_MAX_SRC   = 8;
    localparam int unsigned SKEL_MAX_IDX_W = $clog2(SKEL_MAX_SRC);

    // OR-based encoder: exact for one-hot input, returns 0 for an all-zero vector.
    function automatic logic [SKEL_MAX_IDX_W-1:0] onehot_to_idx(
        input logic [SKEL_MAX_SRC-1:0] oh
    );
        logic [SKEL_MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < SKEL_MAX_SRC; i++) begin
            if (oh[SKEL_MAX_IDX_W'(i)]) begin
                idx = idx | SKEL_MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter for the RAM write port. Picks at most one requester per cycle
// and returns it as a one-hot grant.
//
// Default build: round-robin. The search starts one past the last granted
// index; the pointer only moves when something is granted and resets to
// NUM_SRC-1 so that index 0 wins first.
// With WRARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, and no
// pointer state is kept.
//
// Ports:
//   clk    clock (rising edge)
//   rst_n  synchronous active-low reset
//   req    request vector, one bit per source
//   grant  one-hot grant, all zero when req is all zero
module rr_arbiter
    import skel_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    localparam int unsigned IDW    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] grant
);

`ifdef WRARB_FIXED_PRIO_EN

    // Isolate the lowest set request bit.
    assign grant = req & (~req + NUM_SRC'(1));

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

`else

    logic [IDW-1:0]       last_q, last_d;
    logic [IDW-1:0]       start;
    logic [NUM_SRC-1:0]   rot;
    logic [NUM_SRC-1:0]   pick;
    logic [2*NUM_SRC-1:0] gnt_dbl;

    // Rotate requests right so the preferred source lands on bit 0, take the
    // lowest set bit, then rotate the pick back into source numbering.
    always_comb begin
        start   = (last_q == IDW'(NUM_SRC - 1)) ? '0 : last_q + IDW'(1);
        rot     = NUM_SRC'({req, req} >> start);
        pick    = rot & (~rot + NUM_SRC'(1));
        gnt_dbl = {pick, pick} << start;
        grant   = NUM_SRC'(gnt_dbl >> NUM_SRC);
        last_d  = last_q;
        if (|grant) begin
            last_d = IDW'(onehot_to_idx(SKEL_MAX_SRC'(grant)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= IDW'(NUM_SRC - 1);
        end else begin
            last_q <= last_d;
        end
    end

`endif

endmodule

// File: rtl/ram_write_arbiter.sv
// Merges NUM_SRC independent write streams onto one RAM write port.
// Each source owns a one-entry holding buffer; one buffered beat per cycle is
// granted (while the RAM is not busy) and presented on a registered write
// port one cycle later.
//
// Build option: define WRARB_FIXED_PRIO_EN for fixed-priority arbitration
// (lowest source index wins); otherwise round-robin. Ports are the same.
//
// Ports:
//   clk        clock (rising edge)
//   rst_n      synchronous active-low reset; discards buffered beats
//   src_valid  per-source write request
//   src_ready  per-source accept (buffer free, or being drained this cycle)
//   src_addr   packed addresses, source i at [i*ADDR_W +: ADDR_W]
//   src_data   packed data, source i at [i*PIXEL_W +: PIXEL_W]
//   ram_busy   RAM cannot take a write this cycle
//   ram_we     registered one-cycle write strobe
//   ram_addr   registered write address, held while ram_we is low
//   ram_data   registered write data, held while ram_we is low
//   grant_id   source index of the current ram_we beat, held while ram_we is low
module ram_write_arbiter
    import skel_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned ADDR_W  = SKEL_ADDR_W,
    parameter int unsigned PIXEL_W = SKEL_PIXEL_W,
    localparam int unsigned IDW    = $clog2(NUM_SRC)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0]  src_addr,
    input  logic [NUM_SRC*PIXEL_W-1:0] src_data,
    input  logic                       ram_busy,
    output logic                       ram_we,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [PIXEL_W-1:0]         ram_data,
    output logic [IDW-1:0]             grant_id
);

    logic [NUM_SRC-1:0]              buf_valid;
    logic [NUM_SRC-1:0][ADDR_W-1:0]  buf_addr;
    logic [NUM_SRC-1:0][PIXEL_W-1:0] buf_data;
    logic [NUM_SRC-1:0]              req;
    logic [NUM_SRC-1:0]              grant;
    logic [NUM_SRC-1:0]              push;
    logic [IDW-1:0]                  grant_idx;

    // A busy RAM masks every request, so buffers simply hold.
    assign req = ram_busy ? '0 : buf_valid;

    rr_arbiter #(
        .NUM_SRC(NUM_SRC)
    ) u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .grant(grant)
    );

    // Ready while empty or while the entry leaves this cycle; forced low in reset.
    assign src_ready = {NUM_SRC{rst_n}} & (~buf_valid | grant);
    assign push      = src_valid & src_ready;
    assign grant_idx = IDW'(onehot_to_idx(SKEL_MAX_SRC'(grant)));

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic               valid_q, valid_d;
        logic [ADDR_W-1:0]  addr_q, addr_d;
        logic [PIXEL_W-1:0] data_q, data_d;

        // A push wins over a pop: same-cycle push and grant replaces the entry.
        always_comb begin
            valid_d = valid_q;
            addr_d  = addr_q;
            data_d  = data_q;
            if (push[i]) begin
                valid_d = 1'b1;
                addr_d  = src_addr[i*ADDR_W +: ADDR_W];
                data_d  = src_data[i*PIXEL_W +: PIXEL_W];
            end else if (grant[i]) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                addr_q  <= '0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                addr_q  <= addr_d;
                data_q  <= data_d;
            end
        end

        assign buf_valid[i] = valid_q;
        assign buf_addr[i]  = addr_q;
        assign buf_data[i]  = data_q;
    end

    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [PIXEL_W-1:0] wdata_q, wdata_d;
    logic [IDW-1:0]     wid_q, wid_d;

    always_comb begin
        we_d    = |grant;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wid_d   = wid_q;
        if (|grant) begin
            waddr_d = buf_addr[grant_idx];
            wdata_d = buf_data[grant_idx];
            wid_d   = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wid_q   <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wid_q   <= wid_d;
        end
    end

    assign ram_we   = we_q;
    assign ram_addr = waddr_q;
    assign ram_data = wdata_q;
    assign grant_id = wid_q;

endmodule

// File: tb/tb_ram_write_arbiter.sv
module tb_ram_write_arbiter;

    localparam int N  = 2;
    localparam int AW = 6;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [N*AW-1:0] src_addr;
    logic [N*DW-1:0] src_data;
    logic            ram_busy;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_data;
    logic [0:0]      grant_id;

    ram_write_arbiter #(
        .NUM_SRC(N),
        .ADDR_W (AW),
        .PIXEL_W(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .src_addr (src_addr),
        .src_data (src_data),
        .ram_busy (ram_busy),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: per-source occupancy and contents, arbitration pointer,
    // and the expected registered write port.
    bit            mv [N];
    logic [AW-1:0] ma [N];
    logic [DW-1:0] md [N];
    int            last;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_id;

    // Accepted-but-not-yet-written beats, per source, in acceptance order.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;
    beat_t sb [N][$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick_src();
        if (!rst_n || ram_busy) return -1;
`ifdef WRARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (mv[i]) return i;
`else
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (mv[i]) return i;
        end
`endif
        return -1;
    endfunction

    // Called just after a falling edge with inputs already driven; returns
    // just after the next falling edge.
    task automatic tick();
        int           g;
        logic [N-1:0] er;
        g = pick_src();
        for (int i = 0; i < N; i++) er[i] = rst_n && (!mv[i] || g == i);
        #1;
        chk("src_ready", 32'(src_ready), 32'(er));
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mv[i] = 1'b0;
                sb[i].delete();
            end
            m_we = 1'b0; m_addr = '0; m_data = '0; m_id = 0; last = N - 1;
        end else begin
            m_we = (g >= 0);
            if (g >= 0) begin
                m_addr = ma[g]; m_data = md[g]; m_id = g; last = g;
            end
            for (int i = 0; i < N; i++) begin
                if (src_valid[i] && er[i]) begin
                    beat_t b;
                    mv[i] = 1'b1;
                    ma[i] = src_addr[i*AW +: AW];
                    md[i] = src_data[i*DW +: DW];
                    b.a = ma[i]; b.d = md[i];
                    sb[i].push_back(b);
                end else if (g == i) begin
                    mv[i] = 1'b0;
                end
            end
        end
        #1;
        chk("ram_we", 32'(ram_we), 32'(m_we));
        chk("ram_addr", 32'(ram_addr), 32'(m_addr));
        chk("ram_data", 32'(ram_data), 32'(m_data));
        chk("grant_id", 32'(grant_id), 32'(m_id));
        if (ram_we === 1'b1 && rst_n) begin
            int s;
            s = int'(grant_id);
            chk("sb_has_beat", 32'(sb[s].size() > 0), 32'd1);
            if (sb[s].size() > 0) begin
                beat_t b;
                b = sb[s].pop_front();
                chk("sb_order", {16'h0, ram_addr, ram_data}, {16'h0, b.a, b.d});
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic busy);
        src_valid = v;
        ram_busy  = busy;
        src_addr  = N*AW'($urandom);
        src_data  = N*DW'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; src_valid = '0; src_addr = '0; src_data = '0; ram_busy = 1'b0;
        for (int i = 0; i < N; i++) mv[i] = 1'b0;
        m_we = 1'b0; m_addr = '0; m_data = '0; m_id = 0; last = N - 1;
        @(negedge clk);

        // Reset, then idle after release.
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Single beat from source 0.
        src_valid = 2'b01; src_addr = 12'd5; src_data = 16'h00AA;
        tick();
        src_valid = '0;
        tick();
        chk("single_we", 32'(ram_we), 32'd1);
        chk("single_addr", 32'(ram_addr), 32'd5);
        chk("single_data", 32'(ram_data), 32'hAA);
        chk("single_id", 32'(grant_id), 32'd0);
        repeat (2) tick();

        // Both sources continuously valid.
        repeat (8) begin drive(2'b11, 1'b0); tick(); end
        drive(2'b00, 1'b0); repeat (3) tick();

        // Fill both buffers under busy, hold 3 cycles, then drain.
        drive(2'b11, 1'b1); tick();
        repeat (3) begin
            drive(2'b11, 1'b1); tick();
            chk("busy_no_we", 32'(ram_we), 32'd0);
        end
        drive(2'b00, 1'b0);
        tick(); chk("drain_we0", 32'(ram_we), 32'd1);
        tick(); chk("drain_we1", 32'(ram_we), 32'd1);
        tick();

        // Reset while both buffers are full.
        drive(2'b11, 1'b1); tick();
        drive(2'b00, 1'b1); tick();
        rst_n = 1'b0; drive(2'b00, 1'b0); tick();
        rst_n = 1'b1; drive(2'b00, 1'b0);
        tick(); chk("post_rst_no_we", 32'(ram_we), 32'd0);
        drive(2'b11, 1'b0); tick();
        drive(2'b00, 1'b0); tick();
        chk("post_rst_first_id", 32'(grant_id), 32'd0);
        repeat (3) tick();

        // Random traffic.
        repeat (400) begin
            drive(N'($urandom), ($urandom_range(0, 3) == 0));
            tick();
        end

        // Drain and confirm nothing was dropped.
        drive(2'b00, 1'b0);
        repeat (4) tick();
        for (int i = 0; i < N; i++) chk("sb_drained", 32'(sb[i].size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
